ysyx_22050598_lsu_ctrl: RTL and testbench

//  Load/store stage that consumes the EX/LS pipeline-register outputs.
//  - Issues one valid/ready memory request per load/store.
//  - Aligns store data and byte strobes; extracts and sign/zero-extends load data.
//  - Drives stall back to the EX/LS register and produces registered writeback to WB.
//  - Passes ALU results through with 1-cycle latency.

---
 rtl/ysyx_22050598_lsu_ctrl_if.sv | 21 ++
 rtl/ysyx_22050598_lsu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_22050598_lsu_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050598_lsu_ctrl_if.sv
// Memory request/response channel between the load/store stage and the data memory.
interface ysyx_22050598_lsu_ctrl_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/ysyx_22050598_lsu_ctrl.sv
// Load/store stage: one memory transaction per load/store, store alignment,
// load extraction/extension, ALU pass-through and registered writeback.
//
// state | meaning
// IDLE  | accept next op from EX/LS; ALU ops and misaligned accesses finish here
// REQ   | mem_req_valid high, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid or timeout
module ysyx_22050598_lsu_ctrl #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ls_addr_alu,
    input  logic        ls_alu_rd_en,
    input  logic        ls_load_en,
    input  logic        ls_store_en,
    input  logic [63:0] ls_store_data,
    input  logic [1:0]  ls_data_type,
    input  logic        ls_load_unsigned,
    input  logic [4:0]  ls_rd_idx,
    output logic        ls_stall_o,
    ysyx_22050598_lsu_ctrl_if.master mem,
    output logic        wb_valid_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [63:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [60:0] addr_q;
    logic [2:0]  off_q;
    logic [1:0]  type_q;
    logic        uns_q;
    logic [4:0]  rd_q;
    logic        wen_q;
    logic [7:0]  wstrb_q;
    logic [63:0] wdata_q;
    logic [7:0]  cnt_q;
    logic        wb_valid_q, wb_en_q, misalign_q, bus_err_q;
    logic [4:0]  wb_rd_q;
    logic [63:0] wb_data_q;

    logic        mem_op, misaligned;
    logic [2:0]  off_in;
    logic [7:0]  strb_base;
    logic [63:0] rsp_shift, load_ext;

    // Decode the incoming op: alignment check and store byte-lane base mask.
    always_comb begin
        mem_op     = ls_load_en | ls_store_en;
        off_in     = ls_addr_alu[2:0];
        misaligned = 1'b0;
        strb_base  = 8'h01;
        case (ls_data_type)
            2'b00: strb_base = 8'h01;
            2'b01: begin strb_base = 8'h03; misaligned = ls_addr_alu[0];      end
            2'b10: begin strb_base = 8'h0F; misaligned = |ls_addr_alu[1:0];   end
            default: begin strb_base = 8'hFF; misaligned = |ls_addr_alu[2:0]; end
        endcase
    end

    // Shift response into the low lanes, then truncate and extend to 64 bits.
    always_comb begin
        rsp_shift = mem.mem_rsp_rdata >> {off_q, 3'b000};
        load_ext  = rsp_shift;
        case (type_q)
            2'b00: load_ext = uns_q ? {56'b0, rsp_shift[7:0]}  : {{56{rsp_shift[7]}},  rsp_shift[7:0]};
            2'b01: load_ext = uns_q ? {48'b0, rsp_shift[15:0]} : {{48{rsp_shift[15]}}, rsp_shift[15:0]};
            2'b10: load_ext = uns_q ? {32'b0, rsp_shift[31:0]} : {{32{rsp_shift[31]}}, rsp_shift[31:0]};
            default: load_ext = rsp_shift;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a response on the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (mem_op && !misaligned) state_d = S_REQ;
            S_REQ:  if (mem.mem_req_ready)     state_d = S_WAIT;
            S_WAIT: if (mem.mem_rsp_valid || cnt_q == 8'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; stall releases on the completion cycle.
    always_comb begin
        mem.mem_req_valid = (state_q == S_REQ);
        ls_stall_o = ((state_q == S_IDLE) && mem_op && !misaligned)
                   || (state_q == S_REQ)
                   || ((state_q == S_WAIT) && !mem.mem_rsp_valid);
    end

    // Request fields, timeout down-counter and registered writeback/status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            off_q      <= '0;
            type_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        if (misaligned) begin
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q  <= ls_addr_alu[63:3];
                            off_q   <= off_in;
                            type_q  <= ls_data_type;
                            uns_q   <= ls_load_unsigned;
                            rd_q    <= ls_rd_idx;
                            wen_q   <= ls_store_en;
                            wstrb_q <= ls_store_en ? (strb_base << off_in) : 8'h00;
                            wdata_q <= ls_store_data << {off_in, 3'b000};
                        end
                    end else if (ls_alu_rd_en) begin
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= (ls_rd_idx != 5'd0);
                        wb_rd_q    <= ls_rd_idx;
                        wb_data_q  <= ls_addr_alu;
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) cnt_q <= 8'(RSP_TIMEOUT - 1);
                end
                S_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        if (!wen_q) begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= (rd_q != 5'd0);
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= load_ext;
                        end
                    end else if (cnt_q == 8'd0) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req_addr  = {addr_q, 3'b000};
    assign mem.mem_req_wen   = wen_q;
    assign mem.mem_req_wdata = wdata_q;
    assign mem.mem_req_wstrb = wstrb_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_en_o     = wb_en_q;
    assign wb_rd_idx_o = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_ysyx_22050598_lsu_ctrl.sv
// Directed bench for the load/store stage; memory side driven by hand.
module tb_ysyx_22050598_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ls_addr_alu = '0;
    logic        ls_alu_rd_en = 1'b0;
    logic        ls_load_en = 1'b0;
    logic        ls_store_en = 1'b0;
    logic [63:0] ls_store_data = '0;
    logic [1:0]  ls_data_type = '0;
    logic        ls_load_unsigned = 1'b0;
    logic [4:0]  ls_rd_idx = '0;
    logic        ls_stall_o, wb_valid_o, wb_en_o, misalign_o, bus_err_o;
    logic [4:0]  wb_rd_idx_o;
    logic [63:0] wb_data_o;
    int          n_cmp = 0;
    int          n_err = 0;

    ysyx_22050598_lsu_ctrl_if mem_if();

    ysyx_22050598_lsu_ctrl #(.RSP_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ls_addr_alu(ls_addr_alu), .ls_alu_rd_en(ls_alu_rd_en),
        .ls_load_en(ls_load_en), .ls_store_en(ls_store_en),
        .ls_store_data(ls_store_data), .ls_data_type(ls_data_type),
        .ls_load_unsigned(ls_load_unsigned), .ls_rd_idx(ls_rd_idx),
        .ls_stall_o(ls_stall_o), .mem(mem_if.master),
        .wb_valid_o(wb_valid_o), .wb_en_o(wb_en_o), .wb_rd_idx_o(wb_rd_idx_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ls_alu_rd_en = 1'b0; ls_load_en = 1'b0; ls_store_en = 1'b0;
        ls_addr_alu = '0; ls_store_data = '0; ls_data_type = '0;
        ls_load_unsigned = 1'b0; ls_rd_idx = '0;
    endtask

    task automatic start_load(input logic [63:0] a, input logic [1:0] t, input logic u, input logic [4:0] rd);
        ls_load_en = 1'b1; ls_addr_alu = a; ls_data_type = t;
        ls_load_unsigned = u; ls_rd_idx = rd;
    endtask

    task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] t, input logic u,
                           input logic [4:0] rd, input logic [63:0] rdata, input logic [63:0] exp);
        start_load(a, t, u, rd);
        mem_if.mem_req_ready = 1'b1;
        #1 chk({tag, "_stall_accept"}, 64'(ls_stall_o), 64'd1);
        tick();
        chk({tag, "_req_valid"}, 64'(mem_if.mem_req_valid), 64'd1);
        chk({tag, "_req_addr"}, mem_if.mem_req_addr, {a[63:3], 3'b000});
        chk({tag, "_req_wstrb"}, 64'(mem_if.mem_req_wstrb), 64'd0);
        tick();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = rdata;
        #1 chk({tag, "_stall_done"}, 64'(ls_stall_o), 64'd0);
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        idle_inputs();
        chk({tag, "_wb_valid"}, 64'(wb_valid_o), 64'd1);
        chk({tag, "_wb_en"}, 64'(wb_en_o), 64'(rd != 5'd0));
        chk({tag, "_wb_rd"}, 64'(wb_rd_idx_o), 64'(rd));
        chk({tag, "_wb_data"}, wb_data_o, exp);
        tick();
        chk({tag, "_wb_clear"}, 64'(wb_valid_o), 64'd0);
    endtask

    task automatic do_store(input string tag, input logic [63:0] a, input logic [1:0] t, input logic [63:0] d,
                            input int hold, input logic [7:0] e_strb, input logic [63:0] e_wdata);
        ls_store_en = 1'b1; ls_addr_alu = a; ls_data_type = t; ls_store_data = d;
        mem_if.mem_req_ready = 1'b0;
        tick();
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) mem_if.mem_req_ready = 1'b1;
            #1;
            chk($sformatf("%s_valid%0d", tag, i), 64'(mem_if.mem_req_valid), 64'd1);
            chk($sformatf("%s_stall%0d", tag, i), 64'(ls_stall_o), 64'd1);
            chk($sformatf("%s_addr%0d", tag, i), mem_if.mem_req_addr, {a[63:3], 3'b000});
            chk($sformatf("%s_wen%0d", tag, i), 64'(mem_if.mem_req_wen), 64'd1);
            chk($sformatf("%s_wstrb%0d", tag, i), 64'(mem_if.mem_req_wstrb), 64'(e_strb));
            chk($sformatf("%s_wdata%0d", tag, i), mem_if.mem_req_wdata, e_wdata);
            tick();
        end
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        #1 chk({tag, "_stall_done"}, 64'(ls_stall_o), 64'd0);
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        idle_inputs();
        chk({tag, "_no_wb"}, 64'(wb_valid_o), 64'd0);
        chk({tag, "_idle_valid"}, 64'(mem_if.mem_req_valid), 64'd0);
    endtask

    // Reach WAIT cycle 255 (counter at terminal count) without a response.
    task automatic to_last_wait(input logic [63:0] a);
        start_load(a, 2'b11, 1'b0, 5'd7);
        mem_if.mem_req_ready = 1'b1;
        tick();
        tick();
        mem_if.mem_req_ready = 1'b0;
        idle_inputs();
        for (int i = 0; i < 253; i++) tick();
        chk("to_stall_254", 64'(ls_stall_o), 64'd1);
        chk("to_err_254", 64'(bus_err_o), 64'd0);
        tick();
        chk("to_stall_255", 64'(ls_stall_o), 64'd1);
    endtask

    initial begin
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_rdata = '0;
        #12;
        chk("rst_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        chk("rst_stall", 64'(ls_stall_o), 64'd0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        ls_alu_rd_en = 1'b1; ls_rd_idx = 5'd5; ls_addr_alu = 64'h1234;
        #1 chk("alu_stall", 64'(ls_stall_o), 64'd0);
        tick();
        chk("alu_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("alu_wb_en", 64'(wb_en_o), 64'd1);
        chk("alu_wb_rd", 64'(wb_rd_idx_o), 64'd5);
        chk("alu_wb_data", wb_data_o, 64'h1234);
        ls_rd_idx = 5'd0; ls_addr_alu = 64'hBEEF;
        tick();
        chk("alu_x0_valid", 64'(wb_valid_o), 64'd1);
        chk("alu_x0_en", 64'(wb_en_o), 64'd0);
        idle_inputs();
        mem_if.mem_rsp_valid = 1'b1;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("bubble_valid", 64'(wb_valid_o), 64'd0);
        chk("bubble_en", 64'(wb_en_o), 64'd0);

        // Loads
        do_load("lb", 64'h1003, 2'b00, 1'b0, 5'd10, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 64'h1003, 2'b00, 1'b1, 5'd10, 64'h0000_0000_8000_0000, 64'h80);
        do_load("lh", 64'h100A, 2'b01, 1'b0, 5'd11, 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765);
        do_load("lw", 64'h1004, 2'b10, 1'b0, 5'd12, 64'h7654_3210_0000_0000, 64'h7654_3210);
        do_load("lwu", 64'h1004, 2'b10, 1'b1, 5'd13, 64'h8000_0001_0000_0000, 64'h8000_0001);
        do_load("ld", 64'h1008, 2'b11, 1'b1, 5'd0, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF);

        // Stores, the first with mem_req_ready held low for 4 cycles
        do_store("sh", 64'h1006, 2'b01, 64'hABCD, 4, 8'hC0, 64'hABCD_0000_0000_0000);
        do_store("sb", 64'h1001, 2'b00, 64'h55, 0, 8'h02, 64'h5500);
        do_store("sd", 64'h2000, 2'b11, 64'h0102_0304_0506_0708, 0, 8'hFF, 64'h0102_0304_0506_0708);

        // Misaligned word
        ls_load_en = 1'b1; ls_addr_alu = 64'h1002; ls_data_type = 2'b10; ls_rd_idx = 5'd3;
        #1 chk("mis_stall", 64'(ls_stall_o), 64'd0);
        tick();
        idle_inputs();
        chk("mis_pulse", 64'(misalign_o), 64'd1);
        chk("mis_no_req", 64'(mem_if.mem_req_valid), 64'd0);
        chk("mis_no_wb", 64'(wb_valid_o), 64'd0);
        tick();
        chk("mis_clear", 64'(misalign_o), 64'd0);

        // Response timeout
        to_last_wait(64'h3000);
        tick();
        chk("to_err", 64'(bus_err_o), 64'd1);
        chk("to_stall_idle", 64'(ls_stall_o), 64'd0);
        chk("to_no_wb", 64'(wb_valid_o), 64'd0);
        tick();
        chk("to_err_clear", 64'(bus_err_o), 64'd0);
        chk("to_idle_req", 64'(mem_if.mem_req_valid), 64'd0);

        // Response arriving on the timeout cycle wins
        to_last_wait(64'h3008);
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 64'h0000_0000_0000_0042;
        tick();
        mem_if.mem_rsp_valid = 1'b0;
        chk("race_wb", 64'(wb_valid_o), 64'd1);
        chk("race_data", wb_data_o, 64'h42);
        chk("race_no_err", 64'(bus_err_o), 64'd0);

        // Reset during REQ drops the request at once
        start_load(64'h4000, 2'b11, 1'b0, 5'd9);
        mem_if.mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rstreq_valid", 64'(mem_if.mem_req_valid), 64'd0);
        rst = 1'b0;
        tick();

        // Reset during WAIT
        start_load(64'h4000, 2'b11, 1'b0, 5'd9);
        mem_if.mem_req_ready = 1'b1;
        tick();
        tick();
        mem_if.mem_req_ready = 1'b0;
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rstwait_valid", 64'(mem_if.mem_req_valid), 64'd0);
        chk("rstwait_stall", 64'(ls_stall_o), 64'd0);
        chk("rstwait_wb", 64'(wb_valid_o), 64'd0);
        chk("rstwait_addr", mem_if.mem_req_addr, 64'd0);
        rst = 1'b0;
        tick();
        do_load("post_rst", 64'h4010, 2'b10, 1'b0, 5'd14, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
